uart_receiver: RTL and testbench

- Serial-to-parallel receiver for the board UART link, and the counterpart of the team's parity-framed transmitter.
- Frame format: start bit (0), DATA_BITS data bits LSB first, one parity bit, then one or more stop bits (1).
- Received bytes go into a FIFO-deep shift buffer. The buffer is exposed as an array for the display/LED logic, and the newest byte is also presented on its own.

---
 rtl/uart_receiver.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel receiver for parity-framed UART frames.
// Frame: start(0), DATA_BITS data bits LSB first, one parity bit, stop bit(s)(1).
// Received bytes shift into a FIFO-deep buffer; index 0 is oldest, FIFO-1 newest.
// Optional feature: define RX_MAJORITY_EN for 2-of-3 majority sampling around
// every sample point (decision one cycle later, bit period unchanged).

module uart_receiver #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO         = 4,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    input  logic                         clr,
    output logic                         rx_valid,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overrun,
    output logic [$clog2(FIFO+1)-1:0]    count,
    output logic [DATA_BITS-1:0]         last,
    output logic [DATA_BITS-1:0]         rx_buf [0:FIFO-1],
    output logic                         busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned NW = $clog2(FIFO + 1);

    localparam logic [CW-1:0] HALF_T   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_T   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO);
    localparam logic          ODD      = 1'(PARITY_ODD);

`ifdef RX_MAJORITY_EN
    // Decision lands one cycle past the nominal point, so the next bit starts at 1.
    localparam logic [CW-1:0] RESTART = CW'(1);
`else
    localparam logic [CW-1:0] RESTART = '0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          counter_q, counter_d;
    logic [IW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;

    logic                   rx_meta, rxs, rxs_d;
    logic [CW-1:0]          target;
    logic                   sample_now;
    logic                   sample_bit;
    logic                   stop_ok;
    logic                   stop_bad;

    // Frame-completion pipeline: stage 1 holds the finished byte, stage 2 delays flags.
    logic                   p1_store, p1_ferr, p1_perr;
    logic [DATA_BITS-1:0]   p1_data;
    logic                   p2_store, p2_ferr;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

`ifdef RX_MAJORITY_EN
    logic maj_a, maj_b;

    // Capture the two early votes at T-1 and T; the third vote is rxs at T+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            maj_a <= 1'b1;
            maj_b <= 1'b1;
        end else begin
            if (counter_q == target - CW'(1)) begin
                maj_a <= rxs;
            end
            if (counter_q == target) begin
                maj_b <= rxs;
            end
        end
    end

    // Sample point is T+1 with a 2-of-3 vote.
    always_comb begin
        target     = (state_q == StStart) ? HALF_T : FULL_T;
        sample_now = (counter_q == target + CW'(1));
        sample_bit = (maj_a & maj_b) | (maj_a & rxs) | (maj_b & rxs);
    end
`else
    // Sample point is T with a single sample.
    always_comb begin
        target     = (state_q == StStart) ? HALF_T : FULL_T;
        sample_now = (counter_q == target);
        sample_bit = rxs;
    end
`endif

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            counter_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
        end
    end

    // Next-state logic: bit timing, data capture and stop-bit decision.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;

        unique case (state_q)
            StIdle: begin
                counter_d = '0;
                if (rxs_d && !rxs) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (sample_now) begin
                    if (sample_bit) begin
                        // Line went back high before mid start bit: a glitch.
                        state_d   = StIdle;
                        counter_d = '0;
                    end else begin
                        state_d   = StData;
                        counter_d = RESTART;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (sample_now) begin
                    shreg_d[bit_idx_q] = sample_bit;
                    counter_d          = RESTART;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = StParity;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            StParity: begin
                if (sample_now) begin
                    par_d     = sample_bit;
                    counter_d = RESTART;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (sample_now) begin
                    counter_d = '0;
                    if (sample_bit) begin
                        stop_ok = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StBreak;
                    end
                end
            end
            StBreak: begin
                // Hold here until the line is released so a long low is not a new start.
                counter_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                counter_d = '0;
            end
        endcase
    end

    // Two-stage delay from the stop decision to the store and the output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_store <= 1'b0;
            p1_ferr  <= 1'b0;
            p1_perr  <= 1'b0;
            p1_data  <= '0;
            p2_store <= 1'b0;
            p2_ferr  <= 1'b0;
        end else begin
            p1_store <= stop_ok;
            p1_ferr  <= stop_bad;
            if (stop_ok) begin
                p1_data <= shreg_q;
                p1_perr <= ((^shreg_q) ^ par_q) != ODD;
            end
            p2_store <= p1_store;
            p2_ferr  <= p1_ferr;
        end
    end

    // Output pulses and the receive buffer; clr beats a coincident store.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            count      <= '0;
            for (int i = 0; i < FIFO; i++) begin
                rx_buf[i] <= '0;
            end
        end else begin
            rx_valid   <= p2_store;
            parity_err <= p2_store & p1_perr;
            frame_err  <= p2_ferr;
            overrun    <= p2_store & ~clr & (count == FULL_CNT);
            if (clr) begin
                count <= '0;
                for (int i = 0; i < FIFO; i++) begin
                    rx_buf[i] <= '0;
                end
            end else if (p2_store) begin
                for (int i = 0; i < FIFO - 1; i++) begin
                    rx_buf[i] <= rx_buf[i+1];
                end
                rx_buf[FIFO-1] <= p1_data;
                if (count != FULL_CNT) begin
                    count <= count + NW'(1);
                end
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign last = rx_buf[FIFO-1];

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven frames with a scoreboard of expected stores,
// plus hand-written sequences for framing error, glitch, reset and clear.

module tb_uart_receiver;

    localparam int DB  = 8;
    localparam int CPB = 16;
    localparam int FD  = 4;
    // Line fall -> rx_valid: 2 sync flops + edge detect, half bit, 10 bit periods, 2 stages.
    localparam int LAT = 3 + CPB / 2 + CPB * (DB + 2) + 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      rx  = 1'b1;
    logic                      clr = 1'b0;
    logic                      rx_valid, parity_err, frame_err, overrun, busy;
    logic [$clog2(FD+1)-1:0]   count;
    logic [DB-1:0]             last;
    logic [DB-1:0]             rx_buf [0:FD-1];

    uart_receiver #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB),
        .FIFO         (FD),
        .PARITY_ODD   (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .clr        (clr),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .count      (count),
        .last       (last),
        .rx_buf     (rx_buf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] last;
        logic       perr;
        logic       ovr;
        int         cnt;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       flip;
        int         stops;
        logic       clr_before;
        logic       ovr;
        int         cnt;
    } vec_t;

    exp_t sb [$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every rx_valid must match the oldest expected store.
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (!rx_valid && (parity_err || overrun)) begin
            total++;
            bad++;
            $display("FAIL stray_pulse: parity_err=%0b overrun=%0b, required 0 without rx_valid",
                     parity_err, overrun);
        end
        if (rx_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: last=%0h, required no rx_valid", last);
            end else begin
                mon_e = sb.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                check("last", {24'd0, last}, {24'd0, mon_e.last});
                check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
                check("overrun", {31'd0, overrun}, {31'd0, mon_e.ovr});
                check("count", {29'd0, count}, mon_e.cnt);
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic perr, input logic ovr, input int cnt);
        exp_t e;
        e.last = d;
        e.perr = perr;
        e.ovr  = ovr;
        e.cnt  = cnt;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stopv,
                              input int nstop);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(p);
        for (int i = 0; i < nstop; i++) drive_bit(stopv);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: %0d expected rx_valid pulses missing, required 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_buf(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_buf [4];
        exp_buf = '{e0, e1, e2, e3};
        for (int i = 0; i < FD; i++) begin
            check($sformatf("%s[%0d]", name, i), {24'd0, rx_buf[i]}, {24'd0, exp_buf[i]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        int   v0, f0;

        vecs[0] = '{data: 8'hA5, flip: 1'b0, stops: 1, clr_before: 1'b0, ovr: 1'b0, cnt: 1};
        vecs[1] = '{data: 8'h3C, flip: 1'b1, stops: 1, clr_before: 1'b0, ovr: 1'b0, cnt: 2};
        vecs[2] = '{data: 8'h11, flip: 1'b0, stops: 2, clr_before: 1'b1, ovr: 1'b0, cnt: 1};
        vecs[3] = '{data: 8'h22, flip: 1'b0, stops: 2, clr_before: 1'b0, ovr: 1'b0, cnt: 2};
        vecs[4] = '{data: 8'h33, flip: 1'b0, stops: 2, clr_before: 1'b0, ovr: 1'b0, cnt: 3};
        vecs[5] = '{data: 8'h44, flip: 1'b0, stops: 2, clr_before: 1'b0, ovr: 1'b0, cnt: 4};
        vecs[6] = '{data: 8'h55, flip: 1'b0, stops: 2, clr_before: 1'b0, ovr: 1'b1, cnt: 4};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_last", {24'd0, last}, 32'd0);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check_buf("reset_buf", 8'h00, 8'h00, 8'h00, 8'h00);

        // Table-driven frames; back-to-back within each group.
        for (int k = 0; k < 7; k++) begin
            if (vecs[k].clr_before) begin
                wait_drain("drain_before_clr");
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                check("clr_count", {29'd0, count}, 32'd0);
            end
            push_exp(vecs[k].data, vecs[k].flip, vecs[k].ovr, vecs[k].cnt);
            send_frame(vecs[k].data, (^vecs[k].data) ^ vecs[k].flip, 1'b1, vecs[k].stops);
        end
        wait_drain("drain_table");
        check("table_valid_cnt", valid_cnt, 32'd7);
        check("table_ferr_cnt", ferr_cnt, 32'd0);
        check("table_count", {29'd0, count}, 32'd4);
        check_buf("table_buf", 8'h22, 8'h33, 8'h44, 8'h55);

        // Stop bit forced low, line held low: one frame_err, buffer untouched.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h7E, ^8'h7E, 1'b0, 1);
        repeat (40) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_ferr_cnt", ferr_cnt - f0, 32'd1);
        check("break_no_valid", valid_cnt - v0, 32'd0);
        check("break_count", {29'd0, count}, 32'd4);
        check_buf("break_buf", 8'h22, 8'h33, 8'h44, 8'h55);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_release_busy", {31'd0, busy}, 32'd0);

        // Short low glitch: busy rises then falls, nothing reported.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", valid_cnt - v0, 32'd0);
        check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

        // Reset after three data bits abandons the frame.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_last", {24'd0, last}, 32'd0);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(8'h81, 1'b0, 1'b0, 1);
        send_frame(8'h81, ^8'h81, 1'b1, 1);
        wait_drain("drain_81");
        check_buf("after_81_buf", 8'h00, 8'h00, 8'h00, 8'h81);

        // clr coincident with the store of 0x99: byte dropped, rx_valid still pulses.
        v0 = valid_cnt;
        push_exp(8'h00, 1'b0, 1'b0, 0);
        fork
            send_frame(8'h99, ^8'h99, 1'b1, 1);
            begin
                repeat (LAT - 1) @(negedge clk);
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end
        join
        wait_drain("drain_99");
        check("clr_store_valid", valid_cnt - v0, 32'd1);
        check("clr_store_count", {29'd0, count}, 32'd0);
        check_buf("clr_store_buf", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
